param_reservation_station: RTL and testbench
============================================

PARAM_RESERVATION_STATION -- requirements
Module: param_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of entries (power of two, 4..64).
REQ-002 SHALL have parameter TAG_W, default 5, meaning ROB tag width; tag 0 means "operand ready".
REQ-003 SHALL have parameter OP_W, default 7, meaning opcode width.
REQ-004 SHALL have parameter XLEN, default 32, meaning operand/pc/imm width.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port rdy  in  1  global enable; low freezes all state.
REQ-008 SHALL have port flush  in  1  mispredict commit; discard all entries.
REQ-009 SHALL have ports disp_valid in 1, disp_op in OP_W, disp_pc/disp_imm/disp_Vi/disp_Vj in XLEN, disp_Qi/disp_Qj/disp_rob in TAG_W: dispatch request.
REQ-010 SHALL have port rs_full  out  1  no free entry; combinational from count.
REQ-011 SHALL have port rs_count  out  $clog2(DEPTH+1)  occupied entries, registered.
REQ-012 SHALL have ports cdb0_valid in 1, cdb0_tag in TAG_W, cdb0_data in XLEN (ALU broadcast) and cdb1_valid/cdb1_tag/cdb1_data identically (LSB broadcast).
REQ-013 SHALL have ports iss_valid out 1, iss_ready in 1, iss_op out OP_W, iss_Vi/iss_Vj/iss_imm/iss_pc out XLEN, iss_rob out TAG_W: issue to ALU.

Function
REQ-014 Each entry SHALL hold busy, op, pc, imm, Vi, Vj, Qi, Qj, rob and an age rank; entry ready = busy && Qi==0 && Qj==0.
REQ-015 Dispatch SHALL be accepted when disp_valid && !rs_full && rdy, writing the lowest-index free entry at the clock edge.
REQ-016 Dispatch with rs_full high SHALL be ignored; no entry written, no count change.
REQ-017 Wakeup: on a CDB with valid && tag!=0, every busy entry with Qi (Qj) == tag SHALL load Vi (Vj) = data and clear Qi (Qj) at that edge.
REQ-018 Both CDB ports SHALL be applied in the same edge; if both carry the same tag, cdb0 data wins.
REQ-019 Dispatch bypass: if disp_Qi (disp_Qj) matches a valid CDB tag in the dispatch cycle, the entry SHALL store the CDB data with Q=0.
REQ-020 Selection SHALL choose the oldest ready entry (earliest dispatch), not lowest index; age ranks SHALL remain a strict total order across wrap of entry indices.
REQ-021 Issue output SHALL be a register stage: it loads when (!iss_valid || iss_ready) and a ready entry exists; the selected entry is freed at that same edge.
REQ-022 iss_valid and all iss_* payload SHALL hold stable while iss_valid && !iss_ready.
REQ-023 When the stage empties with no ready entry, iss_valid SHALL drop to 0 and payload SHALL be 0.
REQ-024 Latency: entry dispatched with ready operands at edge N SHALL present iss_valid after edge N+1 (if stage free); entry woken at edge E SHALL be selectable from edge E+1 (no same-edge wakeup-select).
REQ-025 Simultaneous dispatch and issue-free in one edge SHALL both occur; rs_count unchanged; freed entry reusable next cycle.
REQ-026 rs_count SHALL equal popcount(busy) at all times; rs_full = (rs_count == DEPTH).
REQ-027 flush SHALL (when rdy) clear all busy bits, rs_count, iss_valid and payload at the edge, overriding dispatch, wakeup and issue in that cycle.
REQ-028 rdy low SHALL hold every register (entries, count, issue stage); dispatch and CDB inputs in that cycle are ignored.

Reset
REQ-029 rst low SHALL immediately clear all busy bits, age ranks, Q/V fields, rs_count=0, iss_valid=0, all iss_* payload=0; rs_full=0.
REQ-030 Reset assertion mid-handshake SHALL abort the pending issue; first dispatch after release SHALL land in entry 0.

Verification
REQ-031 Dispatch op=0x33, Qi=Qj=0, Vi=5, Vj=7, rob=3, iss_ready=1 -> iss_valid after 2nd edge, iss_Vi=5, iss_Vj=7, iss_rob=3, rs_count back to 0.
REQ-032 Dispatch rob=4 with Qi=2; then cdb1 tag=2 data=0xAA -> next-cycle selection, iss_Vi=0xAA; cdb with tag 0 changes nothing.
REQ-033 Dispatch rob=5 (Qi=9) then rob=6 (ready) then wake tag 9; hold iss_ready=0 -> rob=6 issues first and stays stable; release -> rob=5 next.
REQ-034 Fill DEPTH entries with Qi=1 -> rs_full=1, extra dispatch dropped, rs_count=DEPTH; one cdb0 tag=1 -> all ready, issued oldest-first in dispatch order.
REQ-035 Dispatch with disp_Qj=7 while cdb0 tag=7 data=0x1234 -> entry stored Qj=0, Vj=0x1234.
REQ-036 Flush with 3 entries and iss_valid=1, concurrent disp_valid -> rs_count=0, iss_valid=0, dispatch dropped; rst pulse mid-stall -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/param_reservation_station.sv
// Reservation station feeding one ALU: dispatch into the lowest free slot, wake operands
// from two CDBs, and issue the oldest ready entry through a registered issue stage.
module param_reservation_station #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5,
    parameter int OP_W  = 7,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       disp_valid,
    input  logic [OP_W-1:0]            disp_op,
    input  logic [XLEN-1:0]            disp_pc,
    input  logic [XLEN-1:0]            disp_imm,
    input  logic [XLEN-1:0]            disp_Vi,
    input  logic [XLEN-1:0]            disp_Vj,
    input  logic [TAG_W-1:0]           disp_Qi,
    input  logic [TAG_W-1:0]           disp_Qj,
    input  logic [TAG_W-1:0]           disp_rob,
    output logic                       rs_full,
    output logic [$clog2(DEPTH+1)-1:0] rs_count,
    input  logic                       cdb0_valid,
    input  logic [TAG_W-1:0]           cdb0_tag,
    input  logic [XLEN-1:0]            cdb0_data,
    input  logic                       cdb1_valid,
    input  logic [TAG_W-1:0]           cdb1_tag,
    input  logic [XLEN-1:0]            cdb1_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [XLEN-1:0]            iss_Vi,
    output logic [XLEN-1:0]            iss_Vj,
    output logic [XLEN-1:0]            iss_imm,
    output logic [XLEN-1:0]            iss_pc,
    output logic [TAG_W-1:0]           iss_rob
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [DEPTH-1:0][OP_W-1:0]   op_q, op_d;
    logic [DEPTH-1:0][XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, vi_q, vi_d, vj_q, vj_d;
    logic [DEPTH-1:0][TAG_W-1:0]  qi_q, qi_d, qj_q, qj_d, rob_q, rob_d;
    logic [DEPTH-1:0][IW-1:0]     age_q, age_d;
    logic [CW-1:0]                count_q, count_d;

    logic                         issValid_q, issValid_d;
    logic [OP_W-1:0]              issOp_q, issOp_d;
    logic [XLEN-1:0]              issVi_q, issVi_d, issVj_q, issVj_d;
    logic [XLEN-1:0]              issImm_q, issImm_d, issPc_q, issPc_d;
    logic [TAG_W-1:0]             issRob_q, issRob_d;

    logic                         selFound, freeFound, issueLoad, dispAccept;
    logic [IW-1:0]                selIdx, selAge, freeIdx, newAge;
    logic [XLEN-1:0]              dispVi, dispVj;
    logic [TAG_W-1:0]             dispQi, dispQj;

    function automatic logic cdbHit(input logic v, input logic [TAG_W-1:0] t,
                                    input logic [TAG_W-1:0] q);
        return v && (t != '0) && (t == q);
    endfunction

    assign rs_full    = (count_q == CW'(DEPTH));
    assign rs_count   = count_q;
    assign issueLoad  = selFound && (!issValid_q || iss_ready);
    assign dispAccept = disp_valid && !rs_full && freeFound;
    assign newAge     = IW'(count_q - CW'(issueLoad));

    // Age ranks are dense (0 = oldest), so the oldest ready entry has the smallest rank.
    always_comb begin
        selFound  = 1'b0;
        selIdx    = '0;
        selAge    = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && qi_q[i] == '0 && qj_q[i] == '0 &&
                (!selFound || age_q[i] < selAge)) begin
                selFound = 1'b1;
                selIdx   = IW'(i);
                selAge   = age_q[i];
            end
            if (!busy_q[i] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IW'(i);
            end
        end
    end

    // cdb1 is applied before cdb0 so that cdb0 wins on a shared tag.
    always_comb begin
        dispVi = disp_Vi;
        dispQi = disp_Qi;
        dispVj = disp_Vj;
        dispQj = disp_Qj;
        if (cdbHit(cdb1_valid, cdb1_tag, disp_Qi)) begin dispVi = cdb1_data; dispQi = '0; end
        if (cdbHit(cdb0_valid, cdb0_tag, disp_Qi)) begin dispVi = cdb0_data; dispQi = '0; end
        if (cdbHit(cdb1_valid, cdb1_tag, disp_Qj)) begin dispVj = cdb1_data; dispQj = '0; end
        if (cdbHit(cdb0_valid, cdb0_tag, disp_Qj)) begin dispVj = cdb0_data; dispQj = '0; end
    end

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        pc_d   = pc_q;
        imm_d  = imm_q;
        vi_d   = vi_q;
        vj_d   = vj_q;
        qi_d   = qi_q;
        qj_d   = qj_q;
        rob_d  = rob_q;
        age_d  = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i]) begin
                if (cdbHit(cdb1_valid, cdb1_tag, qi_q[i])) begin vi_d[i] = cdb1_data; qi_d[i] = '0; end
                if (cdbHit(cdb0_valid, cdb0_tag, qi_q[i])) begin vi_d[i] = cdb0_data; qi_d[i] = '0; end
                if (cdbHit(cdb1_valid, cdb1_tag, qj_q[i])) begin vj_d[i] = cdb1_data; qj_d[i] = '0; end
                if (cdbHit(cdb0_valid, cdb0_tag, qj_q[i])) begin vj_d[i] = cdb0_data; qj_d[i] = '0; end
                if (issueLoad && age_q[i] > selAge) begin
                    age_d[i] = age_q[i] - 1'b1;
                end
            end
            if (issueLoad && selIdx == IW'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (dispAccept && freeIdx == IW'(i)) begin
                busy_d[i] = 1'b1;
                op_d[i]   = disp_op;
                pc_d[i]   = disp_pc;
                imm_d[i]  = disp_imm;
                vi_d[i]   = dispVi;
                vj_d[i]   = dispVj;
                qi_d[i]   = dispQi;
                qj_d[i]   = dispQj;
                rob_d[i]  = disp_rob;
                age_d[i]  = newAge;
            end
        end
        count_d = count_q + CW'(dispAccept) - CW'(issueLoad);
    end

    // The issue stage holds while stalled and drops to all-zero when it drains empty.
    always_comb begin
        issValid_d = issValid_q;
        issOp_d    = issOp_q;
        issVi_d    = issVi_q;
        issVj_d    = issVj_q;
        issImm_d   = issImm_q;
        issPc_d    = issPc_q;
        issRob_d   = issRob_q;
        if (issueLoad) begin
            issValid_d = 1'b1;
            issOp_d    = op_q[selIdx];
            issVi_d    = vi_q[selIdx];
            issVj_d    = vj_q[selIdx];
            issImm_d   = imm_q[selIdx];
            issPc_d    = pc_q[selIdx];
            issRob_d   = rob_q[selIdx];
        end else if (iss_ready) begin
            issValid_d = 1'b0;
            issOp_d    = '0;
            issVi_d    = '0;
            issVj_d    = '0;
            issImm_d   = '0;
            issPc_d    = '0;
            issRob_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            op_q       <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            vi_q       <= '0;
            vj_q       <= '0;
            qi_q       <= '0;
            qj_q       <= '0;
            rob_q      <= '0;
            age_q      <= '0;
            count_q    <= '0;
            issValid_q <= 1'b0;
            issOp_q    <= '0;
            issVi_q    <= '0;
            issVj_q    <= '0;
            issImm_q   <= '0;
            issPc_q    <= '0;
            issRob_q   <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy_q     <= '0;
                age_q      <= '0;
                count_q    <= '0;
                issValid_q <= 1'b0;
                issOp_q    <= '0;
                issVi_q    <= '0;
                issVj_q    <= '0;
                issImm_q   <= '0;
                issPc_q    <= '0;
                issRob_q   <= '0;
            end else begin
                busy_q     <= busy_d;
                op_q       <= op_d;
                pc_q       <= pc_d;
                imm_q      <= imm_d;
                vi_q       <= vi_d;
                vj_q       <= vj_d;
                qi_q       <= qi_d;
                qj_q       <= qj_d;
                rob_q      <= rob_d;
                age_q      <= age_d;
                count_q    <= count_d;
                issValid_q <= issValid_d;
                issOp_q    <= issOp_d;
                issVi_q    <= issVi_d;
                issVj_q    <= issVj_d;
                issImm_q   <= issImm_d;
                issPc_q    <= issPc_d;
                issRob_q   <= issRob_d;
            end
        end
    end

    assign iss_valid = issValid_q;
    assign iss_op    = issOp_q;
    assign iss_Vi    = issVi_q;
    assign iss_Vj    = issVj_q;
    assign iss_imm   = issImm_q;
    assign iss_pc    = issPc_q;
    assign iss_rob   = issRob_q;

endmodule

// File: tb/tb_param_reservation_station.sv
// Directed bench for param_reservation_station: a vector table for single-cycle behaviour
// plus hand sequences for ordering, stalls, fill/drain, rdy freeze, flush and async reset.
module tb_param_reservation_station;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        disp_valid;
    logic [6:0]  disp_op;
    logic [31:0] disp_pc, disp_imm, disp_Vi, disp_Vj;
    logic [4:0]  disp_Qi, disp_Qj, disp_rob;
    logic        rs_full;
    logic [4:0]  rs_count;
    logic        cdb0_valid, cdb1_valid;
    logic [4:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_data, cdb1_data;
    logic        iss_valid, iss_ready;
    logic [6:0]  iss_op;
    logic [31:0] iss_Vi, iss_Vj, iss_imm, iss_pc;
    logic [4:0]  iss_rob;

    int passed = 0;
    int total  = 0;

    param_reservation_station #(.DEPTH(16), .TAG_W(5), .OP_W(7), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc), .disp_imm(disp_imm),
        .disp_Vi(disp_Vi), .disp_Vj(disp_Vj), .disp_Qi(disp_Qi), .disp_Qj(disp_Qj),
        .disp_rob(disp_rob), .rs_full(rs_full), .rs_count(rs_count),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_Vi(iss_Vi), .iss_Vj(iss_Vj), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_rob(iss_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [31:0] vi, vj;
        logic [4:0]  qi, qj, rob;
        logic        c0v;
        logic [4:0]  c0t;
        logic [31:0] c0d;
        logic        c1v;
        logic [4:0]  c1t;
        logic [31:0] c1d;
        logic        issReady;
        logic        expValid;
        logic [4:0]  expRob;
        logic [31:0] expVi, expVj;
        int          expCount;
    } vecT;

    vecT vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Payload derives op/pc/imm from the rob tag, so only rob/Vi/Vj/count need listing.
    task automatic checkIssue(input string name, input logic ev, input logic [4:0] erob,
                              input logic [31:0] evi, input logic [31:0] evj, input int ecnt);
        logic [31:0] expOp, expPc, expImm;
        expOp  = ev ? 32'(7'h30 + 7'(erob)) : 32'h0;
        expPc  = ev ? 32'h1000 + 32'(erob) : 32'h0;
        expImm = ev ? 32'(erob) * 2 : 32'h0;
        checkOutput({name, ".iss_valid"}, 32'(iss_valid), 32'(ev));
        checkOutput({name, ".iss_rob"},   32'(iss_rob),   ev ? 32'(erob) : 32'h0);
        checkOutput({name, ".iss_Vi"},    iss_Vi,         ev ? evi : 32'h0);
        checkOutput({name, ".iss_Vj"},    iss_Vj,         ev ? evj : 32'h0);
        checkOutput({name, ".iss_op"},    32'(iss_op),    expOp);
        checkOutput({name, ".iss_pc"},    iss_pc,         expPc);
        checkOutput({name, ".iss_imm"},   iss_imm,        expImm);
        checkOutput({name, ".rs_count"},  32'(rs_count),  32'(ecnt));
        checkOutput({name, ".rs_full"},   32'(rs_full),   32'(ecnt == 16));
    endtask

    task automatic clearInputs();
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_op    = '0;
        disp_pc    = '0;
        disp_imm   = '0;
        disp_Vi    = '0;
        disp_Vj    = '0;
        disp_Qi    = '0;
        disp_Qj    = '0;
        disp_rob   = '0;
        cdb0_valid = 1'b0;
        cdb0_tag   = '0;
        cdb0_data  = '0;
        cdb1_valid = 1'b0;
        cdb1_tag   = '0;
        cdb1_data  = '0;
    endtask

    task automatic setDispatch(input logic [31:0] vi, input logic [31:0] vj,
                               input logic [4:0] qi, input logic [4:0] qj, input logic [4:0] rob);
        disp_valid = 1'b1;
        disp_op    = 7'h30 + 7'(rob);
        disp_pc    = 32'h1000 + 32'(rob);
        disp_imm   = 32'(rob) * 2;
        disp_Vi    = vi;
        disp_Vj    = vj;
        disp_Qi    = qi;
        disp_Qj    = qj;
        disp_rob   = rob;
    endtask

    task automatic applyStimulus(input vecT v);
        clearInputs();
        if (v.dv) setDispatch(v.vi, v.vj, v.qi, v.qj, v.rob);
        cdb0_valid = v.c0v;
        cdb0_tag   = v.c0t;
        cdb0_data  = v.c0d;
        cdb1_valid = v.c1v;
        cdb1_tag   = v.c1t;
        cdb1_data  = v.c1d;
        iss_ready  = v.issReady;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          dv  vi       vj       qi  qj  rob  c0v c0t c0d        c1v c1t c1d       rdy ev erob evi      evj      cnt
        vecs[0] = '{1'b1, 32'h5,  32'h7,  5'd0, 5'd0, 5'd3, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0,  32'h0,    1};
        vecs[1] = '{1'b0, 32'h0,  32'h0,  5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd3, 32'h5,  32'h7,    0};
        vecs[2] = '{1'b0, 32'h0,  32'h0,  5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0,  32'h0,    0};
        vecs[3] = '{1'b1, 32'h0,  32'h11, 5'd2, 5'd0, 5'd4, 1'b1, 5'd0, 32'hFF,   1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0,  32'h0,    1};
        vecs[4] = '{1'b0, 32'h0,  32'h0,  5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hEE,   1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0,  32'h0,    1};
        vecs[5] = '{1'b0, 32'h0,  32'h0,  5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 32'hAA,   1'b1, 1'b0, 5'd0, 32'h0,  32'h0,    1};
        vecs[6] = '{1'b0, 32'h0,  32'h0,  5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd4, 32'hAA, 32'h11,   0};
        vecs[7] = '{1'b1, 32'h55, 32'h0,  5'd0, 5'd7, 5'd8, 1'b1, 5'd7, 32'h1234, 1'b1, 5'd7, 32'h9999, 1'b1, 1'b0, 5'd0, 32'h0,  32'h0,    1};
        vecs[8] = '{1'b0, 32'h0,  32'h0,  5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd8, 32'h55, 32'h1234, 0};
        vecs[9] = '{1'b0, 32'h0,  32'h0,  5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0,  32'h0,    0};

        // Reset with a dispatch pending: nothing may be written while rst is low.
        rst = 1'b0;
        rdy = 1'b1;
        iss_ready = 1'b1;
        clearInputs();
        setDispatch(32'h1, 32'h2, 5'd0, 5'd0, 5'd3);
        #2;
        checkIssue("reset_async", 1'b0, 5'd0, 32'h0, 32'h0, 0);
        tick();
        checkIssue("reset_held", 1'b0, 5'd0, 32'h0, 32'h0, 0);
        #4;
        rst = 1'b1;
        clearInputs();

        for (int r = 0; r < 10; r++) begin
            applyStimulus(vecs[r]);
            tick();
            checkIssue($sformatf("vec%0d", r), vecs[r].expValid, vecs[r].expRob,
                       vecs[r].expVi, vecs[r].expVj, vecs[r].expCount);
        end

        // rdy low freezes everything, including dispatch and issue.
        clearInputs();
        rdy = 1'b0;
        setDispatch(32'h12, 32'h13, 5'd0, 5'd0, 5'd12);
        tick();
        checkIssue("rdy_disp_ignored", 1'b0, 5'd0, 32'h0, 32'h0, 0);
        rdy = 1'b1;
        tick();
        checkIssue("rdy_disp", 1'b0, 5'd0, 32'h0, 32'h0, 1);
        clearInputs();
        rdy = 1'b0;
        tick();
        checkIssue("rdy_no_issue", 1'b0, 5'd0, 32'h0, 32'h0, 1);
        rdy = 1'b1;
        tick();
        checkIssue("rdy_issue", 1'b1, 5'd12, 32'h12, 32'h13, 0);
        rdy = 1'b0;
        tick();
        checkIssue("rdy_hold_stage", 1'b1, 5'd12, 32'h12, 32'h13, 0);
        rdy = 1'b1;
        tick();
        checkIssue("rdy_drain", 1'b0, 5'd0, 32'h0, 32'h0, 0);

        // Older-but-waiting rob5 vs younger-ready rob6, with a stalled issue stage.
        iss_ready = 1'b0;
        clearInputs();
        setDispatch(32'h0, 32'h22, 5'd9, 5'd0, 5'd5);
        tick();
        checkIssue("age_d5", 1'b0, 5'd0, 32'h0, 32'h0, 1);
        clearInputs();
        setDispatch(32'h66, 32'h67, 5'd0, 5'd0, 5'd6);
        tick();
        checkIssue("age_d6", 1'b0, 5'd0, 32'h0, 32'h0, 2);
        clearInputs();
        cdb0_valid = 1'b1; cdb0_tag = 5'd9; cdb0_data = 32'h99;
        tick();
        checkIssue("age_iss6", 1'b1, 5'd6, 32'h66, 32'h67, 1);
        clearInputs();
        cdb0_valid = 1'b1; cdb0_tag = 5'd0; cdb0_data = 32'hBAD;
        tick();
        checkIssue("stall1", 1'b1, 5'd6, 32'h66, 32'h67, 1);
        tick();
        checkIssue("stall2", 1'b1, 5'd6, 32'h66, 32'h67, 1);
        clearInputs();
        iss_ready = 1'b1;
        tick();
        checkIssue("age_iss5", 1'b1, 5'd5, 32'h99, 32'h22, 0);
        tick();
        checkIssue("age_drain", 1'b0, 5'd0, 32'h0, 32'h0, 0);

        // Fill to capacity, drop an extra dispatch, wake all, then drain oldest-first
        // while a young ready entry reuses slot 0.
        for (int k = 0; k < 16; k++) begin
            clearInputs();
            setDispatch(32'h0, 32'(k), 5'd1, 5'd0, 5'(10 + k));
            tick();
        end
        checkIssue("fill", 1'b0, 5'd0, 32'h0, 32'h0, 16);
        clearInputs();
        setDispatch(32'h30, 32'h31, 5'd0, 5'd0, 5'd30);
        tick();
        checkIssue("full_drop", 1'b0, 5'd0, 32'h0, 32'h0, 16);
        clearInputs();
        cdb0_valid = 1'b1; cdb0_tag = 5'd1; cdb0_data = 32'h77;
        tick();
        checkIssue("wake_all", 1'b0, 5'd0, 32'h0, 32'h0, 16);
        clearInputs();
        tick();
        checkIssue("drain_first", 1'b1, 5'd10, 32'h77, 32'h0, 15);
        for (int m = 0; m < 16; m++) begin
            clearInputs();
            if (m == 0) setDispatch(32'h30, 32'h31, 5'd0, 5'd0, 5'd30);
            tick();
            if (m < 15) checkIssue($sformatf("drain%0d", m), 1'b1, 5'(11 + m), 32'h77, 32'(1 + m), 15 - m);
            else        checkIssue("drain_young", 1'b1, 5'd30, 32'h30, 32'h31, 0);
        end
        clearInputs();
        tick();
        checkIssue("drain_empty", 1'b0, 5'd0, 32'h0, 32'h0, 0);

        // Flush with three waiting entries, a stalled issue and a concurrent dispatch.
        iss_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            clearInputs();
            setDispatch(32'(k), 32'(k + 16), 5'd0, 5'd0, 5'(k));
            tick();
        end
        checkIssue("pre_flush", 1'b1, 5'd1, 32'h1, 32'h11, 3);
        clearInputs();
        flush = 1'b1;
        setDispatch(32'h5, 32'h6, 5'd0, 5'd0, 5'd5);
        tick();
        checkIssue("flush", 1'b0, 5'd0, 32'h0, 32'h0, 0);
        clearInputs();
        tick();
        checkIssue("post_flush", 1'b0, 5'd0, 32'h0, 32'h0, 0);

        // Async reset in the middle of a stalled handshake.
        setDispatch(32'h7, 32'h8, 5'd0, 5'd0, 5'd7);
        tick();
        clearInputs();
        setDispatch(32'h9, 32'hA, 5'd0, 5'd0, 5'd8);
        tick();
        checkIssue("pre_rst", 1'b1, 5'd7, 32'h7, 32'h8, 1);
        rst = 1'b0;
        #1;
        checkIssue("rst_async", 1'b0, 5'd0, 32'h0, 32'h0, 0);
        #1;
        rst = 1'b1;
        clearInputs();
        iss_ready = 1'b1;
        setDispatch(32'h19, 32'h1A, 5'd0, 5'd0, 5'd9);
        tick();
        checkIssue("post_rst_disp", 1'b0, 5'd0, 32'h0, 32'h0, 1);
        clearInputs();
        tick();
        checkIssue("post_rst_iss", 1'b1, 5'd9, 32'h19, 32'h1A, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
